// File: rtl/sha2_msg_sched_if.sv
// Valid/ready bundle for the SHA-2 message-schedule unit: message-word input stream,
// schedule-word output stream, block start and busy status.
interface sha2_msg_sched_if #(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64
);
  localparam int IDX_W = $clog2(ROUNDS);

  logic              start_i;
  logic              in_valid_i;
  logic [WORD_W-1:0] in_data_i;
  logic              in_ready_o;
  logic              out_valid_o;
  logic [WORD_W-1:0] out_data_o;
  logic [IDX_W-1:0]  out_idx_o;
  logic              out_last_o;
  logic              out_ready_i;
  logic              busy_o;

  modport master (
    output start_i, in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, out_idx_o, out_last_o, busy_o
  );

  modport slave (
    input  start_i, in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, out_idx_o, out_last_o, busy_o
  );
endinterface

// File: rtl/sha2_msg_sched.sv
// Streaming SHA-2 message schedule: loads 16 words, then emits W[0..ROUNDS-1] one per cycle.
// Optional macro SCHED_ABORT_EN adds abort_i to cancel a block in LOAD or EMIT.
module sha2_msg_sched #(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64
) (
  input  logic              clk,
  input  logic              n_reset,
`ifdef SCHED_ABORT_EN
  input  logic              abort_i,
`endif
  sha2_msg_sched_if.slave   bus
);
  localparam int IDX_W = $clog2(ROUNDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

  if (WORD_W != 32 && WORD_W != 64) begin : g_bad_word_w
    $error("sha2_msg_sched: WORD_W must be 32 or 64");
  end
  if (ROUNDS < 16 || ROUNDS > 128) begin : g_bad_rounds
    $error("sha2_msg_sched: ROUNDS must be in 16..128");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_EMIT = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [WORD_W-1:0] r_win [16];
  logic [WORD_W-1:0] w_win_next [16];
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_next;
  logic [IDX_W-1:0]  r_t;
  logic [IDX_W-1:0]  w_t_next;
  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_clear;
  logic              w_abort;
  logic              w_shift;
  logic [WORD_W-1:0] w_ss0;
  logic [WORD_W-1:0] w_ss1;
  logic [WORD_W-1:0] w_n;
  logic [WORD_W-1:0] w_shift_in;

`ifdef SCHED_ABORT_EN
  assign w_abort = abort_i;
`else
  assign w_abort = 1'b0;
`endif

  // Small sigmas on the window taps feeding the next schedule word
  if (WORD_W == 64) begin : g_sig64
    assign w_ss0 = {r_win[1][0:0],   r_win[1][WORD_W-1:1]}
                 ^ {r_win[1][7:0],   r_win[1][WORD_W-1:8]}
                 ^ (r_win[1] >> 7);
    assign w_ss1 = {r_win[14][18:0], r_win[14][WORD_W-1:19]}
                 ^ {r_win[14][60:0], r_win[14][WORD_W-1:61]}
                 ^ (r_win[14] >> 6);
  end else begin : g_sig32
    assign w_ss0 = {r_win[1][6:0],   r_win[1][WORD_W-1:7]}
                 ^ {r_win[1][17:0],  r_win[1][WORD_W-1:18]}
                 ^ (r_win[1] >> 3);
    assign w_ss1 = {r_win[14][16:0], r_win[14][WORD_W-1:17]}
                 ^ {r_win[14][18:0], r_win[14][WORD_W-1:19]}
                 ^ (r_win[14] >> 10);
  end

  assign w_n = w_ss1 + r_win[9] + w_ss0 + r_win[0];

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_t_next     = r_t;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    w_clear      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start_i) w_state_next = S_LOAD;
      end
      S_LOAD: begin
        w_in_ready = 1'b1;
        if (bus.in_valid_i) begin
          w_cnt_next = r_cnt + 4'd1;
          if (r_cnt == 4'd15) begin
            w_state_next = S_EMIT;
            w_t_next     = '0;
          end
        end
      end
      S_EMIT: begin
        w_out_valid = 1'b1;
        if (bus.out_ready_i) begin
          if (r_t == LAST_IDX) begin
            w_state_next = S_IDLE;
            w_t_next     = '0;
          end else begin
            w_t_next = r_t + 1'b1;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
    // Abort wins over any transfer in the same cycle
    if (w_abort && r_state != S_IDLE) begin
      w_state_next = S_IDLE;
      w_cnt_next   = '0;
      w_t_next     = '0;
      w_clear      = 1'b1;
      w_in_ready   = w_in_ready;
    end
  end

  assign w_shift    = (w_in_ready && bus.in_valid_i) || (w_out_valid && bus.out_ready_i);
  assign w_shift_in = (r_state == S_LOAD) ? bus.in_data_i : w_n;

  for (genvar gi = 0; gi < 16; gi++) begin : g_win
    if (gi == 15) begin : g_tail
      assign w_win_next[gi] = w_clear ? '0 : (w_shift ? w_shift_in : r_win[gi]);
    end else begin : g_body
      assign w_win_next[gi] = w_clear ? '0 : (w_shift ? r_win[gi+1] : r_win[gi]);
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_cnt <= '0;
      r_t   <= '0;
      for (int i = 0; i < 16; i++) r_win[i] <= '0;
    end else begin
      r_cnt <= w_cnt_next;
      r_t   <= w_t_next;
      r_win <= w_win_next;
    end
  end

  assign bus.in_ready_o  = w_in_ready;
  assign bus.out_valid_o = w_out_valid;
  assign bus.out_data_o  = r_win[0];
  assign bus.out_idx_o   = r_t;
  assign bus.out_last_o  = w_out_valid && (r_t == LAST_IDX);
  assign bus.busy_o      = (r_state != S_IDLE);
endmodule

// File: tb/tb_sha2_msg_sched.sv
// Scoreboard bench for sha2_msg_sched: 32/64 and 64/80 instances checked against a
// recurrence model of the SHA-2 schedule, with back-pressure, gaps, reset and abort cases.
module tb_sha2_msg_sched;
  logic clk = 1'b0;
  logic n_reset;
  always #5 clk = ~clk;

  sha2_msg_sched_if #(.WORD_W(32), .ROUNDS(64)) b32 ();
  sha2_msg_sched_if #(.WORD_W(64), .ROUNDS(80)) b64 ();

`ifdef SCHED_ABORT_EN
  logic abort32;
`endif

  sha2_msg_sched #(.WORD_W(32), .ROUNDS(64)) u_dut32 (
    .clk     (clk),
    .n_reset (n_reset),
`ifdef SCHED_ABORT_EN
    .abort_i (abort32),
`endif
    .bus     (b32)
  );

  sha2_msg_sched #(.WORD_W(64), .ROUNDS(80)) u_dut64 (
    .clk     (clk),
    .n_reset (n_reset),
`ifdef SCHED_ABORT_EN
    .abort_i (1'b0),
`endif
    .bus     (b64)
  );

  typedef struct {
    logic [63:0] data;
    int          idx;
    bit          last;
  } exp_t;

  exp_t        q32[$];
  exp_t        q64[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [63:0] got32 [64];
  logic [63:0] got64 [80];
  int          first32, last32, xfers32, last_idx64;
  bit          bp32 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: plain SHA-2 schedule recurrence over a word array
  function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int w);
    logic [63:0] m;
    m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    return ((x >> n) | (x << (w - n))) & m;
  endfunction

  function automatic logic [63:0] sig0(input logic [63:0] x, input int w);
    if (w == 32) return rotr(x, 7, 32) ^ rotr(x, 18, 32) ^ (x >> 3);
    return rotr(x, 1, 64) ^ rotr(x, 8, 64) ^ (x >> 7);
  endfunction

  function automatic logic [63:0] sig1(input logic [63:0] x, input int w);
    if (w == 32) return rotr(x, 17, 32) ^ rotr(x, 19, 32) ^ (x >> 10);
    return rotr(x, 19, 64) ^ rotr(x, 61, 64) ^ (x >> 6);
  endfunction

  function automatic void expect_block(input bit is64, input logic [63:0] m[16]);
    logic [63:0] w [128];
    logic [63:0] mask;
    int          ww, r;
    exp_t        e;
    ww   = is64 ? 64 : 32;
    r    = is64 ? 80 : 64;
    mask = is64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    for (int t = 0; t < 16; t++) w[t] = m[t] & mask;
    for (int t = 16; t < r; t++)
      w[t] = (sig1(w[t-2], ww) + w[t-7] + sig0(w[t-15], ww) + w[t-16]) & mask;
    for (int t = 0; t < r; t++) begin
      e.data = w[t];
      e.idx  = t;
      e.last = (t == r - 1);
      if (is64) q64.push_back(e);
      else      q32.push_back(e);
    end
  endfunction

  // Monitor for the 32-bit instance: pops on each transfer and checks stall stability
  initial begin : mon32
    exp_t        e;
    bit          prev_stall;
    logic [31:0] prev_data;
    logic [5:0]  prev_idx;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (n_reset !== 1'b1) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_data32", b32.out_data_o, prev_data);
          check("hold_idx32", b32.out_idx_o, prev_idx);
        end
        prev_stall = b32.out_valid_o && !b32.out_ready_i;
        prev_data  = b32.out_data_o;
        prev_idx   = b32.out_idx_o;
        if (b32.out_valid_o && b32.out_ready_i) begin
          if (q32.size() == 0) begin
            check("unexpected_out32", 64'(b32.out_idx_o), 64'hFFFF);
          end else begin
            e = q32.pop_front();
            $display("[TB] W32 idx=%0d data=%h last=%0b", b32.out_idx_o, b32.out_data_o, b32.out_last_o);
            check("data32", b32.out_data_o, e.data);
            check("idx32", b32.out_idx_o, e.idx);
            check("last32", b32.out_last_o, e.last);
            got32[e.idx] = b32.out_data_o;
            if (e.idx == 0) first32 = cyc;
            if (e.last)     last32  = cyc;
            xfers32++;
          end
        end
      end
    end
  end

  initial begin : mon64
    exp_t e;
    forever begin
      @(negedge clk);
      if (n_reset === 1'b1 && b64.out_valid_o && b64.out_ready_i) begin
        if (q64.size() == 0) begin
          check("unexpected_out64", 64'(b64.out_idx_o), 64'hFFFF);
        end else begin
          e = q64.pop_front();
          $display("[TB] W64 idx=%0d data=%h last=%0b", b64.out_idx_o, b64.out_data_o, b64.out_last_o);
          check("data64", b64.out_data_o, e.data);
          check("idx64", b64.out_idx_o, e.idx);
          check("last64", b64.out_last_o, e.last);
          got64[e.idx] = b64.out_data_o;
          if (b64.out_last_o) last_idx64 = int'(b64.out_idx_o);
        end
      end
    end
  end

  initial begin : bp_drv
    b32.out_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      b32.out_ready_i = bp32 ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic start32();
    @(negedge clk);
    b32.start_i = 1'b1;
    @(negedge clk);
    b32.start_i = 1'b0;
  endtask

  task automatic load32(input logic [63:0] m[16], input int nwords, input bit bubbles, input bit pulse);
    int k = 0;
    int guard = 0;
    bit acc;
    while (k < nwords && guard < 400) begin
      @(negedge clk);
      b32.in_valid_i = bubbles ? 1'($urandom_range(0, 2) != 0) : 1'b1;
      b32.in_data_i  = b32.in_valid_i ? m[k][31:0] : $urandom();
      b32.start_i    = pulse ? 1'($urandom_range(0, 1)) : 1'b0;
      acc = b32.in_ready_o && b32.in_valid_i;
      @(posedge clk);
      if (acc) k++;
      guard++;
    end
    check("load_accepts32", 64'(k), 64'(nwords));
    if (nwords == 16) begin
      #1;
      check("latency_valid32", b32.out_valid_o, 1'b1);
      check("latency_idx32", b32.out_idx_o, 6'd0);
    end
    @(negedge clk);
    b32.in_valid_i = 1'b0;
    b32.start_i    = 1'b0;
  endtask

  task automatic wait_done32(input bit pulse);
    int guard = 0;
    while (guard < 3000) begin
      @(negedge clk);
      #1;
      if (q32.size() == 0 && !b32.busy_o) break;
      if (pulse && b32.out_valid_o && b32.out_idx_o < 6'd56) begin
        b32.start_i    = 1'($urandom_range(0, 1));
        b32.in_valid_i = 1'($urandom_range(0, 1));
        b32.in_data_i  = $urandom();
      end else begin
        b32.start_i    = 1'b0;
        b32.in_valid_i = 1'b0;
      end
      guard++;
    end
    b32.start_i    = 1'b0;
    b32.in_valid_i = 1'b0;
    check("block_done32", 64'(guard < 3000), 64'd1);
  endtask

  task automatic run32(input logic [63:0] m[16], input bit bubbles, input bit pulse);
    xfers32 = 0;
    expect_block(1'b0, m);
    start32();
    load32(m, 16, bubbles, pulse);
    wait_done32(pulse);
    check("xfers32", 64'(xfers32), 64'd64);
  endtask

  task automatic wait_idx32(input int idx);
    int guard = 0;
    while (guard < 1000) begin
      @(negedge clk);
      if (b32.out_valid_o && b32.out_idx_o == 6'(idx)) break;
      guard++;
    end
    check("reach_idx32", 64'(guard < 1000), 64'd1);
  endtask

  logic [63:0] abc32 [16];
  logic [63:0] abc64 [16];
  logic [63:0] rnd   [16];

  initial begin : main
    for (int i = 0; i < 16; i++) begin
      abc32[i] = '0;
      abc64[i] = '0;
    end
    abc32[0]  = 64'h0000_0000_6162_6380;
    abc32[15] = 64'h0000_0000_0000_0018;
    abc64[0]  = 64'h6162_6380_0000_0000;
    abc64[15] = 64'h0000_0000_0000_0018;
`ifdef SCHED_ABORT_EN
    abort32 = 1'b0;
`endif
    b32.start_i = 1'b0; b32.in_valid_i = 1'b0; b32.in_data_i = '0;
    b64.start_i = 1'b0; b64.in_valid_i = 1'b0; b64.in_data_i = '0; b64.out_ready_i = 1'b1;
    n_reset = 1'b0;
    #1;
    check("rst_valid32", b32.out_valid_o, 1'b0);
    check("rst_ready32", b32.in_ready_o, 1'b0);
    check("rst_busy32", b32.busy_o, 1'b0);
    check("rst_last32", b32.out_last_o, 1'b0);
    check("rst_data32", b32.out_data_o, 32'd0);
    check("rst_idx32", b32.out_idx_o, 6'd0);
    check("rst_busy64", b64.busy_o, 1'b0);
    repeat (2) @(negedge clk);
    n_reset = 1'b1;

    // in_valid_i in IDLE must not start or be accepted
    repeat (3) begin
      @(negedge clk);
      b32.in_valid_i = 1'b1;
      b32.in_data_i  = $urandom();
      check("idle_no_ready32", b32.in_ready_o, 1'b0);
    end
    @(negedge clk);
    b32.in_valid_i = 1'b0;
    check("idle_no_busy32", b32.busy_o, 1'b0);

    // SHA-256 "abc", no stalls
    run32(abc32, 1'b0, 1'b0);
    check("abc_w16", got32[16], 64'h6162_6380);
    check("abc_w17", got32[17], 64'h000F_0000);
    check("abc_w63", got32[63], 64'h12B1_EDEB);
    check("throughput32", 64'(last32 - first32), 64'd63);

    // SHA-512 width, 80 rounds
    expect_block(1'b1, abc64);
    @(negedge clk); b64.start_i = 1'b1;
    @(negedge clk); b64.start_i = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      b64.in_valid_i = 1'b1;
      b64.in_data_i  = abc64[k];
    end
    @(negedge clk);
    b64.in_valid_i = 1'b0;
    for (int g = 0; g < 300; g++) begin
      @(negedge clk);
      #1;
      if (q64.size() == 0 && !b64.busy_o) break;
    end
    check("done64", 64'(q64.size()), 64'd0);
    check("abc64_w16", got64[16], 64'h6162_6380_0000_0000);
    check("abc64_w17", got64[17], 64'h0003_0000_0000_00C0);
    check("last_idx64", 64'(last_idx64), 64'd79);

    // Back-pressure on "abc"
    bp32 = 1'b1;
    run32(abc32, 1'b0, 1'b0);
    check("bp_abc_w63", got32[63], 64'h12B1_EDEB);

    // Random blocks with input gaps, stray start/in_valid pulses and stalls
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 16; i++) rnd[i] = {32'd0, $urandom()};
      run32(rnd, 1'b1, 1'b1);
    end
    bp32 = 1'b0;

    // Asynchronous reset mid-EMIT
    expect_block(1'b0, abc32);
    start32();
    load32(abc32, 16, 1'b0, 1'b0);
    wait_idx32(20);
    #2;
    n_reset = 1'b0;
    #1;
    check("async_valid32", b32.out_valid_o, 1'b0);
    check("async_busy32", b32.busy_o, 1'b0);
    check("async_last32", b32.out_last_o, 1'b0);
    check("async_data32", b32.out_data_o, 32'd0);
    check("async_idx32", b32.out_idx_o, 6'd0);
    q32.delete();
    @(negedge clk);
    n_reset = 1'b1;
    run32(abc32, 1'b0, 1'b0);
    check("post_rst_w63", got32[63], 64'h12B1_EDEB);
    check("post_rst_tput", 64'(last32 - first32), 64'd63);

`ifdef SCHED_ABORT_EN
    // Abort in LOAD after 7 words, with a word offered in the abort cycle
    start32();
    load32(abc32, 7, 1'b0, 1'b0);
    abort32        = 1'b1;
    b32.in_valid_i = 1'b1;
    b32.in_data_i  = $urandom();
    @(posedge clk);
    #1;
    check("abort_load_busy", b32.busy_o, 1'b0);
    check("abort_load_ready", b32.in_ready_o, 1'b0);
    @(negedge clk);
    abort32        = 1'b0;
    b32.in_valid_i = 1'b0;
    run32(abc32, 1'b0, 1'b0);
    check("abort_load_w63", got32[63], 64'h12B1_EDEB);

    // Abort in EMIT at t=30
    expect_block(1'b0, abc32);
    start32();
    load32(abc32, 16, 1'b0, 1'b0);
    wait_idx32(30);
    abort32 = 1'b1;
    @(posedge clk);
    #1;
    check("abort_emit_valid", b32.out_valid_o, 1'b0);
    check("abort_emit_busy", b32.busy_o, 1'b0);
    q32.delete();
    @(negedge clk);
    abort32 = 1'b0;
    run32(abc32, 1'b0, 1'b0);
    check("abort_emit_w63", got32[63], 64'h12B1_EDEB);
`endif

    check("q32_empty", 64'(q32.size()), 64'd0);
    check("q64_empty", 64'(q64.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
